// File: rtl/muldiv_hilo_if.sv
// Bus bundle between the pipeline and the HI/LO multiply/divide unit.
// The master side is the pipeline; the slave side is muldiv_hilo.
interface muldiv_hilo_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional DIV_EARLY_OUT_EN: divides with |b| > |a| skip the iteration phase.
module muldiv_hilo #(
  parameter int MUL_CYCLES = 4
) (
  input logic          clk,
  input logic          resetn,
  muldiv_hilo_if.slave bus
);
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t      state_r, state_n;
  logic [4:0]  cnt_r, cnt_n;
  logic [31:0] a_r, a_n, b_r, b_n;
  logic        sgn_r, sgn_n;
  logic [31:0] quo_r, quo_n, rem_r, rem_n, dvs_r, dvs_n;
  logic [31:0] hi_r, hi_n, lo_r, lo_n;
  logic        done_r, done_n;

  logic        is_mul_s, is_div_s, sgn_op_s;
  logic [63:0] ext_a_s, ext_b_s, prod_s;
  logic [32:0] trial_s;
  logic [31:0] mag_a_s, mag_b_s;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      mag = ~v + 32'd1;
    end else begin
      mag = v;
    end
  endfunction

  assign is_mul_s = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div_s = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign sgn_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign mag_a_s  = mag(bus.a, sgn_op_s);
  assign mag_b_s  = mag(bus.b, sgn_op_s);

  // Low 64 bits of a 64x64 product of extended operands serve both signednesses.
  assign ext_a_s = {{32{sgn_r & a_r[31]}}, a_r};
  assign ext_b_s = {{32{sgn_r & b_r[31]}}, b_r};
  assign prod_s  = ext_a_s * ext_b_s;
  assign trial_s = {rem_r, quo_r[31]} - {1'b0, dvs_r};

  // Next-state and datapath decode.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    a_n     = a_r;
    b_n     = b_r;
    sgn_n   = sgn_r;
    quo_n   = quo_r;
    rem_n   = rem_r;
    dvs_n   = dvs_r;
    hi_n    = hi_r;
    lo_n    = lo_r;
    done_n  = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.hi_we) hi_n = bus.wdata; else hi_n = hi_r;
          if (bus.lo_we) lo_n = bus.wdata; else lo_n = lo_r;
          if (bus.start && (is_mul_s || is_div_s)) begin
            a_n   = bus.a;
            b_n   = bus.b;
            sgn_n = sgn_op_s;
            quo_n = mag_a_s;
            rem_n = 32'd0;
            dvs_n = mag_b_s;
            if (is_mul_s) begin
              state_n = MUL;
              cnt_n   = 5'(MUL_CYCLES - 1);
            end else begin
              state_n = DIV;
              cnt_n   = 5'd31;
`ifdef DIV_EARLY_OUT_EN
              if ((bus.b != 32'd0) && (mag_b_s > mag_a_s)) begin
                state_n = FIX;
                cnt_n   = 5'd0;
                quo_n   = 32'd0;
                rem_n   = mag_a_s;
              end else begin
                state_n = DIV;
              end
`endif
            end
          end else begin
            state_n = IDLE;
          end
        end
        MUL: begin
          if (cnt_r == 5'd0) begin
            hi_n    = prod_s[63:32];
            lo_n    = prod_s[31:0];
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_r - 5'd1;
          end
        end
        DIV: begin
          // Restoring step: keep the trial difference only when it did not borrow.
          if (!trial_s[32]) begin
            rem_n = trial_s[31:0];
            quo_n = {quo_r[30:0], 1'b1};
          end else begin
            rem_n = {rem_r[30:0], quo_r[31]};
            quo_n = {quo_r[30:0], 1'b0};
          end
          if (cnt_r == 5'd0) begin
            state_n = FIX;
          end else begin
            cnt_n = cnt_r - 5'd1;
          end
        end
        FIX: begin
          if (b_r == 32'd0) begin
            lo_n = 32'hFFFF_FFFF;
            hi_n = a_r;
          end else begin
            lo_n = (sgn_r && (a_r[31] ^ b_r[31])) ? (~quo_r + 32'd1) : quo_r;
            hi_n = (sgn_r && a_r[31]) ? (~rem_r + 32'd1) : rem_r;
          end
          done_n  = 1'b1;
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sgn_r   <= 1'b0;
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dvs_r   <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      a_r     <= a_n;
      b_r     <= b_n;
      sgn_r   <= sgn_n;
      quo_r   <= quo_n;
      rem_r   <= rem_n;
      dvs_r   <= dvs_n;
      hi_r    <= hi_n;
      lo_r    <= lo_n;
      done_r  <= done_n;
    end
  end

  assign bus.busy = (state_r != IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed literal vectors plus random
// traffic compared every cycle against a cycle-level behavioural model.
module tb_muldiv_hilo;
  localparam int MUL_CYCLES = 4;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  logic clk;
  logic resetn;
  muldiv_hilo_if bus ();

  muldiv_hilo #(.MUL_CYCLES(MUL_CYCLES)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit valid_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb, q, r;
    longint sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (op)
      OP_MULT:  begin sp = longint'(sa) * longint'(sb); return sp; end
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; return up; end
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (op == OP_MULT || op == OP_MULTU) return MUL_CYCLES;
    ma = (op == OP_DIV) ? longint'($signed(a)) : longint'({32'd0, a});
    mb = (op == OP_DIV) ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
    if (b != 32'd0 && mb > ma) return 1;
`endif
    return 33;
  endfunction

  // Behavioural model: remaining busy cycles and the pending result.
  int          m_left;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0; m_res <= 64'd0; m_hi <= 32'd0; m_lo <= 32'd0; m_done <= 1'b0;
    end else if (bus.flush) begin
      m_left <= 0; m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
      m_left <= m_left - 1;
    end else begin
      m_done <= 1'b0;
      if (bus.hi_we) m_hi <= bus.wdata;
      if (bus.lo_we) m_lo <= bus.wdata;
      if (bus.start && valid_op(bus.op)) begin
        m_res  <= ref_result(bus.op, bus.a, bus.b);
        m_left <= latency(bus.op, bus.a, bus.b);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("model_busy", {31'd0, bus.busy}, {31'd0, m_left != 0});
      chk("model_done", {31'd0, bus.done}, {31'd0, m_done});
      chk("model_hi", bus.hi, m_hi);
      chk("model_lo", bus.lo, m_lo);
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_busy);
    int  cnt;
    bit  got;
    cnt = 0;
    got = 1'b0;
    launch(op, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({name, "_busy_cycles"}, cnt, exp_busy);
    chk({name, "_hi"}, bus.hi, exp_hi);
    chk({name, "_lo"}, bus.lo, exp_lo);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] op_tab [7];
  int         bsy_cnt;

  initial begin
    op_tab = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, 4'b0000, 4'b1111, 4'b0011};
    resetn = 1'b0;
    idle_inputs();
    bus.op = 4'd0; bus.a = 32'd0; bus.b = 32'd0; bus.wdata = 32'd0;
    #12;
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_op("mult",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 4);
    run_op("divu",  OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
`ifdef DIV_EARLY_OUT_EN
    run_op("divu_small", OP_DIVU, 32'd5, 32'd9, 32'd5, 32'd0, 1);
`else
    run_op("divu_small", OP_DIVU, 32'd5, 32'd9, 32'd5, 32'd0, 33);
`endif
    run_op("divu_zero", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 33);

    // Flush in the middle of a divide keeps the previous HI/LO.
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    chk("flush_hi", bus.hi, 32'h1234);
    chk("flush_lo", bus.lo, 32'hFFFF_FFFF);
    repeat (40) @(posedge clk);

    // MTHI in IDLE, then a blocked MTHI while busy.
    #1 bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 bus.hi_we = 1'b0;
    @(negedge clk);
    chk("mthi", bus.hi, 32'hDEAD_BEEF);
    launch(OP_DIVU, 32'd100, 32'd7);
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_0055;
    repeat (3) @(negedge clk);
    chk("mthi_busy", bus.hi, 32'hDEAD_BEEF);
    #1 bus.hi_we = 1'b0;
    repeat (40) @(posedge clk);

    // Unrecognised op code must not start anything.
    #1 bus.start = 1'b1; bus.op = 4'b0000;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    chk("bad_op_busy", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset in the middle of a divide.
    launch(OP_DIVU, 32'd100, 32'd7);
    bsy_cnt = 0;
    for (int i = 0; i < 40 && bsy_cnt < 5; i++) begin
      @(negedge clk);
      if (bus.busy) bsy_cnt++;
    end
    chk("pre_reset_busy_seen", bsy_cnt, 5);
    #1 resetn = 1'b0;
    #1;
    chk("midop_reset_hi", bus.hi, 32'd0);
    chk("midop_reset_lo", bus.lo, 32'd0);
    chk("midop_reset_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk); #2 resetn = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op    = op_tab[$urandom_range(0, 6)];
      bus.a     = rand_val();
      bus.b     = rand_val();
      bus.hi_we = ($urandom_range(0, 7) == 0);
      bus.lo_we = ($urandom_range(0, 7) == 0);
      bus.wdata = $urandom;
      bus.flush = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1 idle_inputs();
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
Execute-stage multiply/divide unit that owns the architectural HI/LO registers. It consumes the decode stage's alu_funct codes for MULT/MULTU/DIV/DIVU and its hi_write/lo_write controls (MTHI/MTLO), along with the rs/rt operand values. It runs multi-cycle operations and raises busy so the pipeline stalls around them. HI/LO outputs feed MFHI/MFLO.

Parameters:
MUL_CYCLES, 4, busy cycles for a multiply (legal range 1..8); the product is computed from registered operands and may be retimed across these cycles.

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request a mul/div this cycle
op  input  4  alu_funct code: 4'b1011 MULT, 4'b1100 MULTU, 4'b1101 DIV, 4'b1110 DIVU
a  input  32  rs value (dividend / multiplicand)
b  input  32  rt value (divisor / multiplier)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  32  MTHI/MTLO data (rs value)
flush  input  1  exception/eret kill; aborts any operation in progress
busy  output  1  operation in progress; upstream stalls while high
done  output  1  one-cycle pulse on the cycle HI/LO take a mul/div result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, resetn=0): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, and all internal operand/partial registers are 0.
- States: IDLE, MUL, DIV, FIX.
- busy = (state != IDLE). It is a registered-state decode, with no combinational path from start.
- IDLE, start=1 with a valid op: latch a, b, op. MULT/MULTU go to MUL with counter=MUL_CYCLES-1. DIV/DIVU go to DIV with counter=31.
- start with any other op code is ignored: no state change, busy stays 0.
- start while busy is ignored. Upstream must hold the instruction.
- MUL: decrement counter each cycle. When counter is 0, write {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU), pulse done, and go to IDLE. This gives exactly MUL_CYCLES busy cycles.
- DIV: restoring divide on magnitudes, one quotient bit per cycle. DIV takes |a| and |b| as 32-bit unsigned; |0x80000000| = 0x80000000. DIVU uses the raw values. After 32 iterations, go to FIX.
- FIX (1 cycle):
  - Quotient is negated if sign(a)^sign(b) for DIV.
  - Remainder takes sign(a) for DIV.
  - Write lo=quotient, hi=remainder, pulse done, go to IDLE.
  - Total DIV/DIVU busy = 33 cycles.
- Divide by zero (b=0), DIV or DIVU: still takes 33 cycles. Result is lo=32'hFFFF_FFFF, hi=a, with no sign fixup.
- 0x80000000 / -1 (DIV): lo=0x80000000, hi=0, no exception.
- hi_we/lo_we:
  - Accepted only in IDLE and take effect at the next edge.
  - Ignored while busy, because upstream is stalled.
  - Same cycle as an accepted start: the write happens, and the later mul/div result overwrites it.
- flush: has priority over everything. Any state goes to IDLE at the next edge. hi/lo are unchanged, done=0, and start/hi_we/lo_we in that cycle are ignored.
- done is registered, high for exactly 1 cycle, and 0 otherwise.
- Reset mid-operation: immediate return to reset values. The operation is lost.

Optional Feature:
DIV_EARLY_OUT_EN.
- Defined: in IDLE on DIV/DIVU start, if b != 0 and magnitude(b) > magnitude(a), skip DIV and go straight to FIX with quotient=0 and remainder=magnitude(a). Busy lasts 1 cycle and sign rules still apply.
- Undefined: every divide takes 33 cycles.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, MUL_CYCLES=4 -> busy high 4 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> busy 33 cycles, lo=14, hi=2; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI wdata=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle; hi_we during busy -> hi unchanged; start with op=4'b0000 -> busy stays 0.
- DIVU started, flush at busy cycle 10 -> busy=0 next cycle, hi/lo hold prior values, no done; resetn low at busy cycle 5 -> hi=lo=0, busy=0 immediately.
- With DIV_EARLY_OUT_EN: DIVU a=5, b=9 -> busy 1 cycle, lo=0, hi=5; without it -> busy 33 cycles, same result.
